// File: rtl/mdu_pkg.sv
// mdu_pkg: shared opcodes, FSM states and default latencies for the E-stage multiply/divide unit
package mdu_pkg;
    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } md_op_e;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational HI/LO result generation for every start-type MD op.
// MDU_MADD_EN enables the madd/maddu/msub/msubu accumulate ops.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        is_start,
    output logic        is_div
);
    logic [63:0] acc, prod_s, prod_u, mac, res;
    logic [31:0] ua, ub, uq, ur, q_s, r_s;
    logic        mac_op;

    assign acc    = {hi, lo};
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'b0, a} * {32'b0, b};
    // signed divide on magnitudes so min/-1 wraps instead of being simulator-defined
    assign ua  = a[31] ? -a : a;
    assign ub  = b[31] ? -b : b;
    assign uq  = ua / ub;
    assign ur  = ua % ub;
    assign q_s = (a[31] ^ b[31]) ? -uq : uq;
    assign r_s = a[31] ? -ur : ur;

`ifdef MDU_MADD_EN
    assign mac_op = op == OP_MADD || op == OP_MADDU || op == OP_MSUB || op == OP_MSUBU;
    assign mac    = op == OP_MADD  ? acc + prod_s :
                    op == OP_MADDU ? acc + prod_u :
                    op == OP_MSUB  ? acc - prod_s : acc - prod_u;
`else
    assign mac_op = 1'b0;
    assign mac    = acc;
`endif

    assign is_div   = op == OP_DIV || op == OP_DIVU;
    assign is_start = op == OP_MULT || op == OP_MULTU || is_div || mac_op;
    // a zero divisor re-latches the current HI/LO so the final write is a no-op
    assign res = op == OP_MULT  ? prod_s :
                 op == OP_MULTU ? prod_u :
                 is_div && b == 32'd0 ? acc :
                 op == OP_DIV   ? {r_s, q_s} :
                 op == OP_DIVU  ? {a % b, a / b} : mac;
    assign {res_hi, res_lo} = res;
endmodule

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit owning HI/LO, with md_stall for the hazard unit.
// MDU_MADD_EN (see mdu_arith) adds the madd/msub accumulate family.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);
    state_e      state;
    logic [3:0]  cnt;
    logic [31:0] tmp_hi, tmp_lo, res_hi, res_lo;
    logic        is_start, is_div;

    mdu_arith u_arith (
        .op      (md_op),
        .a       (a),
        .b       (b),
        .hi      (hi),
        .lo      (lo),
        .res_hi  (res_hi),
        .res_lo  (res_lo),
        .is_start(is_start),
        .is_div  (is_div)
    );

    assign busy     = state == RUN;
    assign md_stall = start | busy;
    assign md_out   = md_op == OP_MFHI ? hi : md_op == OP_MFLO ? lo : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            tmp_hi <= 32'd0;
            tmp_lo <= 32'd0;
        end else if (state == IDLE) begin
            if (start && is_start) begin
                tmp_hi <= res_hi;
                tmp_lo <= res_lo;
                cnt    <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                state  <= RUN;
            end else if (!start && md_op == OP_MTHI) begin
                hi <= a;
            end else if (!start && md_op == OP_MTLO) begin
                lo <= a;
            end
        end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                hi    <= tmp_hi;
                lo    <= tmp_lo;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed plus randomized checks of e_mdu against an arithmetic reference model.
module tb_e_mdu;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MDU_MADD_EN
    localparam bit MAC_EN = 1'b1;
`else
    localparam bit MAC_EN = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] a = 32'd0, b = 32'd0;
    logic        busy, md_stall;
    logic [31:0] hi, lo, md_out;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    int          vectors = 0, miscompares = 0;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
        .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo), .md_out(md_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int lat(input logic [3:0] op);
        if (op == OP_MULT || op == OP_MULTU) return MC;
        if (op == OP_DIV || op == OP_DIVU) return DC;
        if (op >= OP_MADD && op <= OP_MSUBU) return MAC_EN ? MC : 0;
        return 0;
    endfunction

    function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y, input logic [63:0] acc);
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint unsigned ux = 64'(x);
        longint unsigned uy = 64'(y);
        case (op)
            OP_MULT:  return 64'(sx * sy);
            OP_MULTU: return ux * uy;
            OP_DIV:   return y == 0 ? acc : {32'(sx % sy), 32'(sx / sy)};
            OP_DIVU:  return y == 0 ? acc : {32'(ux % uy), 32'(ux / uy)};
            OP_MADD:  return acc + 64'(sx * sy);
            OP_MADDU: return acc + ux * uy;
            OP_MSUB:  return acc - 64'(sx * sy);
            OP_MSUBU: return acc - ux * uy;
            default:  return acc;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input bit noise);
        int          n = lat(op);
        logic [63:0] exp = n > 0 ? ref_res(op, x, y, {m_hi, m_lo}) : {m_hi, m_lo};
        start = 1'b1; md_op = op; a = x; b = y;
        #1;
        check("stall_start", 32'(md_stall), 32'd1);
        check("busy_start", 32'(busy), 32'd0);
        step;
        start = 1'b0; md_op = OP_NONE;
        for (int i = 1; i <= n; i++) begin
            if (noise) begin
                start = 1'($urandom_range(1, 0));
                md_op = 4'($urandom_range(12, 0));
                a = $urandom; b = $urandom;
            end
            #1;
            check("busy_run", 32'(busy), 32'd1);
            check("stall_run", 32'(md_stall), 32'd1);
            check("hi_hold", hi, m_hi);
            step;
        end
        {m_hi, m_lo} = exp;
        start = 1'b0; md_op = OP_MFHI;
        #1;
        check("busy_done", 32'(busy), 32'd0);
        check("stall_done", 32'(md_stall), 32'd0);
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        check("mfhi", md_out, m_hi);
        md_op = OP_MFLO;
        #1;
        check("mflo", md_out, m_lo);
        md_op = OP_NONE;
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] x);
        start = 1'b0; md_op = op; a = x;
        #1;
        check("mt_stall", 32'(md_stall), 32'd0);
        step;
        if (op == OP_MTHI) m_hi = x; else m_lo = x;
        md_op = OP_NONE;
        #1;
        check("mt_hi", hi, m_hi);
        check("mt_lo", lo, m_lo);
    endtask

    initial begin
        logic [3:0]  ops[10] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO,
                                 OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
        logic [3:0]  op;
        logic [31:0] x, y;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(md_stall), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_mdout", md_out, 32'd0);
        step;
        reset = 1'b1;
        step;

        run_op(OP_MULT, 32'hFFFFFFFF, 32'd2, 1'b0);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFE);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        mt(OP_MTHI, 32'h1234);
        run_op(OP_DIVU, 32'd100, 32'd0, 1'b0);
        check("divz_hi", hi, 32'h1234);
        run_op(4'd13, 32'd7, 32'd7, 1'b0);
        run_op(OP_MFHI, 32'd7, 32'd7, 1'b0);

        mt(OP_MTLO, 32'hABCD);
        start = 1'b1; md_op = OP_MULT; a = 32'd3; b = 32'd3;
        step;
        start = 1'b0; md_op = OP_NONE;
        step;
        reset = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        step;
        reset = 1'b1;
        for (int i = 0; i < MC + 2; i++) begin
            step;
            check("arst_nolate_busy", 32'(busy), 32'd0);
            check("arst_nolate_lo", lo, 32'd0);
        end

        mt(OP_MTLO, 32'd5);
        mt(OP_MTHI, 32'd0);
        run_op(OP_MADD, 32'd3, 32'd4, 1'b0);
        check("madd_lo", lo, MAC_EN ? 32'd17 : 32'd5);
        check("madd_hi", hi, 32'd0);

        for (int k = 0; k < 40; k++) begin
            op = ops[$urandom_range(9, 0)];
            x = $urandom;
            y = $urandom_range(4, 0) == 0 ? 32'd0 : $urandom;
            if (op == OP_DIV && x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'd1;
            if (op == OP_MTHI || op == OP_MTLO) mt(op, x);
            else run_op(op, x, y, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit for the P6 pipelined MIPS core. It accepts mult/multu/div/divu and mthi/mtlo operations from the E stage and runs multi-cycle arithmetic with an internal countdown. It owns the architectural HI/LO registers and serves mfhi/mflo reads combinationally. It produces `md_stall`, which the hazard/stall unit uses to freeze D while an MD-class instruction is waiting on the unit.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (and madd family when enabled).
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  E-stage instruction is a start-type MD op (mult/multu/div/divu, madd family); valid for one cycle.
- `md_op`  in  4  operation code (values in Structure).
- `a`  in  32  forwarded rs value.
- `b`  in  32  forwarded rt value.
- `busy`  out  1  computation in progress.
- `md_stall`  out  1  `start | busy`; drives the stall unit's MD input.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.
- `md_out`  out  32  `hi` for MFHI, `lo` for MFLO, else 0; combinational.

## Operation
- States: IDLE, RUN. The counter `cnt` is 4 bits.
- IDLE with `start=1` and a valid start op:
  - Latch the result into `tmp_hi`/`tmp_lo`.
  - Load `cnt = MULT_CYCLES` or `DIV_CYCLES`.
  - Go to RUN.
- RUN: `busy=1`, and `cnt` decrements each cycle. When `cnt==1`, HI/LO are written from the tmp registers, `busy` falls, and the unit returns to IDLE.
- Arithmetic:
  - MULT: signed 32×32→64; HI=[63:32], LO=[31:0].
  - MULTU: unsigned 32×32→64.
  - DIV: signed; LO=quotient (truncate toward zero), HI=remainder (sign of dividend).
  - DIVU: unsigned.
- Divide by zero: the full latency elapses, and HI/LO stay unchanged.
- MTHI/MTLO (`start=0`), in IDLE: HI or LO is written with `a` at the next edge, and `md_stall` does not assert. In RUN they are ignored, because the stall unit guarantees none arrive.
- `start` in RUN: ignored, and the current operation continues.
- `md_op` values not listed in Structure: no state change.
- Reset, at any time including mid-operation: immediately returns to IDLE, with `cnt=0`, `busy=0`, and HI=LO=tmp=0.

## Timing
- Reset values: `busy=0`, `md_stall=0`, `hi=0`, `lo=0`, `md_out=0`.
- Cycle T has `start=1`. `md_stall=1` in T through T+N. `busy=1` in T+1 through T+N. HI/LO show the new value from T+N+1. N is the configured cycle count.
- Back-to-back: a new `start` is accepted in T+N+1.
- `md_out` is combinational from the current `hi`/`lo`. An mfhi in E at T+N+1 reads the new value.

## Configuration
- `MDU_MADD_EN` defined:
  - MADD/MADDU: {HI,LO} += a×b, signed or unsigned.
  - MSUB/MSUBU: {HI,LO} −= a×b.
  - These ops take MULT_CYCLES. The accumulate uses the HI/LO values sampled at `start`.
- `MDU_MADD_EN` not defined: those opcodes decode as no-op, with no busy and no state change.

## Structure
- Shared package `mdu_pkg`:
  - `md_op` encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
  - State enum.
  - Default cycle constants.
- Sub-module `mdu_arith`: combinational product/quotient/remainder generation for all ops. It is instantiated once.
- Top level holds the FSM, counter, and HI/LO.

## Test plan
- Reset, then MULT a=0xFFFFFFFF, b=2 → `md_stall` high 6 cycles (T..T+5); then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- DIV a=−7 (0xFFFFFFF9), b=2 → 11 cycles `md_stall`; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100, b=0 after MTHI 0x1234 → full latency, and HI stays 0x1234.
- MULT started, `reset` pulsed low at T+2 → `busy=0` immediately, HI=LO=0, and no late write occurs.
- With `MDU_MADD_EN`: MTLO 5, MTHI 0, then MADD a=3, b=4 → LO=17, HI=0. Without the macro, the same sequence gives LO=5 and `busy` never asserts.
